// File: rtl/ising_pkg.sv
// rtl/ising_pkg.sv - shared types, sizing helpers and pair indexing for the Ising run sequencer
package ising_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        SETTLE,
        SAMPLE,
        DONE
    } run_state_t;

    localparam int DEF_N           = 3;
    localparam int DEF_NUM_WEIGHTS = 5;

    function automatic int ww_of(input int num_weights);
        return (num_weights > 1) ? $clog2(num_weights) : 1;
    endfunction

    function automatic int np_of(input int n);
        return n * (n - 1) / 2;
    endfunction

    function automatic int aw_of(input int np);
        return (np > 1) ? $clog2(np) : 1;
    endfunction

    // Upper-triangle pair (i,j), i<j, flattened row by row.
    function automatic int pair_index(input int n, input int i, input int j);
        return n * i - i * (i + 1) / 2 + j - i - 1;
    endfunction

    localparam int WW = ww_of(DEF_NUM_WEIGHTS);
    localparam int NP = np_of(DEF_N);

endpackage

// File: rtl/ising_phase_counter.sv
// rtl/ising_phase_counter.sv - saturating phase-mismatch counter with majority threshold flag
module ising_phase_counter #(
    parameter int MAX = 128,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    input  logic mismatch,
    output logic over
);

    logic [W-1:0] count;
    logic [W-1:0] count_inc;

    always_comb begin
        count_inc = count;
        if (en && mismatch && (count != W'(MAX))) begin
            count_inc = count + 1'b1;
        end
    end

    // Threshold looks at the count including the current sample so the last one is not lost.
    assign over = (count_inc > W'(MAX / 2));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/ising_run_ctrl.sv
// rtl/ising_run_ctrl.sv - anneal run sequencer and weight register; optional ISING_RUN_CTRL_SYNC_EN input synchronizer
module ising_run_ctrl
    import ising_pkg::*;
#(
    parameter int N             = DEF_N,
    parameter int NUM_WEIGHTS   = DEF_NUM_WEIGHTS,
    parameter int WEIGHT_RESET  = 2,
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 256,
    parameter int SAMPLE_CYCLES = 128
) (
    input  logic                                       clk,
    input  logic                                       rstn,
    input  logic                                       wr_valid,
    output logic                                       wr_ready,
    input  logic [aw_of(np_of(N))-1:0]                 wr_addr,
    input  logic [ww_of(NUM_WEIGHTS)-1:0]              wr_data,
    input  logic                                       start,
    input  logic                                       abort,
    output logic                                       busy,
    output logic                                       core_rstn,
    output logic [ww_of(NUM_WEIGHTS)*np_of(N)-1:0]     core_weights,
    input  logic [N-1:0]                               core_out,
    output logic                                       res_valid,
    input  logic                                       res_ready,
    output logic [N-1:0]                               res_spins
);

    localparam int WGT_W = ww_of(NUM_WEIGHTS);
    localparam int PAIRS = np_of(N);

`ifdef ISING_RUN_CTRL_SYNC_EN
    localparam int SETTLE_LEN = SETTLE_CYCLES + 2;
`else
    localparam int SETTLE_LEN = SETTLE_CYCLES;
`endif

    localparam int CNT_MAX = (RST_CYCLES > SETTLE_LEN)
                           ? ((RST_CYCLES > SAMPLE_CYCLES) ? RST_CYCLES : SAMPLE_CYCLES)
                           : ((SETTLE_LEN > SAMPLE_CYCLES) ? SETTLE_LEN : SAMPLE_CYCLES);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    run_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              mm_clr;
    logic              spins_load;
    logic              wr_en;
    logic [N-1:0]      s;
    logic [N-1:0]      over;
    logic [WGT_W*PAIRS-1:0] weights_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        mm_clr     = 1'b0;
        spins_load = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RST;
                    cnt_nxt   = CNT_W'(RST_CYCLES - 1);
                end
            end
            RST: begin
                if (cnt == '0) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = CNT_W'(SETTLE_LEN - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = SAMPLE;
                    mm_clr    = 1'b1;
                    cnt_nxt   = CNT_W'(SAMPLE_CYCLES - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            SAMPLE: begin
                if (cnt == '0) begin
                    state_nxt  = DONE;
                    spins_load = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        // Abort outranks every other transition, including the DONE handshake.
        if (abort && (state != IDLE)) begin
            state_nxt  = IDLE;
            cnt_nxt    = '0;
            mm_clr     = 1'b0;
            spins_load = 1'b0;
        end
    end

    assign wr_en = (state == IDLE) && wr_valid && (int'(wr_addr) < PAIRS);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < PAIRS; k++) begin
                weights_q[k*WGT_W +: WGT_W] <= WGT_W'(WEIGHT_RESET);
            end
        end else begin
            for (int k = 0; k < PAIRS; k++) begin
                if (wr_en && (int'(wr_addr) == k)) begin
                    weights_q[k*WGT_W +: WGT_W] <= wr_data;
                end
            end
        end
    end

`ifdef ISING_RUN_CTRL_SYNC_EN
    logic [N-1:0] sync_q1, sync_q2;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= core_out;
            sync_q2 <= sync_q1;
        end
    end

    assign s = sync_q2;
`else
    assign s = core_out;
`endif

    assign over[0] = 1'b0;

    for (genvar i = 1; i < N; i++) begin : g_mm
        ising_phase_counter #(
            .MAX (SAMPLE_CYCLES),
            .W   ($clog2(SAMPLE_CYCLES + 1))
        ) u_mm (
            .clk      (clk),
            .rstn     (rstn),
            .clr      (mm_clr),
            .en       (state == SAMPLE),
            .mismatch (s[i] ^ s[0]),
            .over     (over[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            res_spins <= '0;
        end else if (spins_load) begin
            res_spins <= over;
        end
    end

    assign wr_ready     = (state == IDLE);
    assign busy         = (state != IDLE);
    assign res_valid    = (state == DONE);
    assign core_rstn    = (state == SETTLE) || (state == SAMPLE) || (state == DONE);
    assign core_weights = weights_q;

endmodule

// File: tb/tb_ising_run_ctrl.sv
// tb/tb_ising_run_ctrl.sv - directed self-checking bench for ising_run_ctrl
module tb_ising_run_ctrl;
    import ising_pkg::*;

    localparam int RC = 4;
    localparam int SC = 8;
    localparam int MC = 8;
`ifdef ISING_RUN_CTRL_SYNC_EN
    localparam int LAT = RC + SC + MC + 2;
`else
    localparam int LAT = RC + SC + MC;
`endif
    localparam int W0 = RC + SC + 1;

    logic              clk = 1'b0;
    logic              rstn;
    logic              wr_valid;
    logic              wr_ready;
    logic [1:0]        wr_addr;
    logic [WW-1:0]     wr_data;
    logic              start;
    logic              abort;
    logic              busy;
    logic              core_rstn;
    logic [WW*NP-1:0]  core_weights;
    logic [2:0]        core_out;
    logic              res_valid;
    logic              res_ready;
    logic [2:0]        res_spins;

    int checks   = 0;
    int failures = 0;

    ising_run_ctrl #(
        .N             (3),
        .NUM_WEIGHTS   (5),
        .WEIGHT_RESET  (2),
        .RST_CYCLES    (RC),
        .SETTLE_CYCLES (SC),
        .SAMPLE_CYCLES (MC)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .core_rstn    (core_rstn),
        .core_weights (core_weights),
        .core_out     (core_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_spins    (res_spins)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic write_weight(input logic [1:0] addr, input logic [WW-1:0] data);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // k1/k2: number of sample cycles where oscillator 1/2 is inverted against oscillator 0.
    task automatic run(input string tag, input int k1, input int k2, input int abort_at,
                       input logic [2:0] exp_spins);
        logic s0, m1, m2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= LAT; c++) begin
            if (c == 1) begin
                check({tag, "_busy_rst"}, 32'(busy), 32'd1);
                check({tag, "_rstn_rst"}, 32'(core_rstn), 32'd0);
            end
            if (c == RC + 3) check({tag, "_rstn_settle"}, 32'(core_rstn), 32'd1);
            if (abort_at != 0 && c == abort_at + 1) begin
                abort = 1'b0;
                core_out = 3'b000;
                check({tag, "_abort_busy"}, 32'(busy), 32'd0);
                check({tag, "_abort_rstn"}, 32'(core_rstn), 32'd0);
                check({tag, "_abort_valid"}, 32'(res_valid), 32'd0);
                return;
            end
            if (c == LAT) check({tag, "_valid_early"}, 32'(res_valid), 32'd0);
            s0 = c[0];
            m1 = (c >= W0) && (c - W0 < k1);
            m2 = (c >= W0) && (c - W0 < k2);
            core_out = {s0 ^ m2, s0 ^ m1, s0};
            abort = (c == abort_at);
            @(negedge clk);
        end
        core_out = 3'b000;
        check({tag, "_valid"}, 32'(res_valid), 32'd1);
        check({tag, "_spins"}, 32'(res_spins), 32'(exp_spins));
    endtask

    task automatic ack(input string tag);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_ack_busy"}, 32'(busy), 32'd0);
        check({tag, "_ack_valid"}, 32'(res_valid), 32'd0);
    endtask

    initial begin
        rstn      = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        start     = 1'b0;
        abort     = 1'b0;
        core_out  = '0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_core_rstn", 32'(core_rstn), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_spins", 32'(res_spins), 32'd0);
        check("rst_weights", 32'(core_weights), 32'h092);
        rstn = 1'b1;

        write_weight(2'(pair_index(3, 1, 2)), 3'd4);
        check("wr_pair12", 32'(core_weights), 32'h112);
        write_weight(2'd3, 3'd1);
        check("wr_oob_ignored", 32'(core_weights), 32'h112);

        run("inphase", 0, 0, 0, 3'b000);
        ack("inphase");
        run("anti5", 0, 5, 0, 3'b100);
        ack("anti5");
        run("anti4", 0, 4, 0, 3'b000);
        ack("anti4");
        run("osc1_all", 8, 0, 0, 3'b010);
        ack("osc1_all");

        // Write together with start lands on the start edge; then abort from RST.
        @(negedge clk);
        start    = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 2'd0;
        wr_data  = 3'd3;
        @(negedge clk);
        start    = 1'b0;
        wr_valid = 1'b0;
        check("wr_start_busy", 32'(busy), 32'd1);
        check("wr_start_weights", 32'(core_weights), 32'h113);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_rst_busy", 32'(busy), 32'd0);

        run("abort", 0, 5, RC + 3, 3'b000);
        run("post_abort", 5, 5, 0, 3'b110);

        for (int h = 0; h < 10; h++) begin
            start    = 1'b1;
            wr_valid = 1'b1;
            wr_addr  = 2'd1;
            wr_data  = 3'd0;
            @(negedge clk);
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_spins", 32'(res_spins), 32'h6);
            check("hold_rstn", 32'(core_rstn), 32'd1);
            check("hold_wr_ready", 32'(wr_ready), 32'd0);
            check("hold_weights", 32'(core_weights), 32'h113);
        end
        start    = 1'b0;
        wr_valid = 1'b0;
        ack("hold");
        check("hold_ack_rstn", 32'(core_rstn), 32'd0);
        @(negedge clk);
        check("start_not_queued", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
